// File: rtl/pattern_serializer.sv
// Serializes a parallel word MSB-first, one bit per rising edge of freq_2, with a
// frame strobe, an end-of-frame pulse and a configurable idle gap between frames.
module pattern_serializer #(
  parameter int DATA_W    = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic              clk_freq1,
  input  logic              rst_key1,
  input  logic              freq_2,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              frame_out,
  output logic              busy,
  output logic              done_pulse
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [7:0]        GAP_INIT = 8'(GAP_TICKS);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, GAP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic                ser_q, ser_d;
  logic                frame_q, frame_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                f2_dly_q, f2_dly_d;
  logic                tick;

  // freq_2 is only a tick source; its rising edge is detected in the clk_freq1 domain.
  assign tick      = freq_2 & ~f2_dly_q;
  assign din_ready = (state_q == IDLE) & ~rst_key1;

  assign ser_out    = ser_q;
  assign frame_out  = frame_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ser_d     = ser_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    f2_dly_d  = freq_2;

    unique case (state_q)
      IDLE: begin
        // A tick landing in the capture cycle is deliberately not acted on.
        if (din_valid) begin
          shreg_d = din;
          state_d = ARM;
        end
      end
      ARM: begin
        if (tick) begin
          ser_d     = shreg_q[DATA_W-1];
          frame_d   = 1'b1;
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = BIT_LAST;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt_q == '0) begin
            frame_d = 1'b0;
            ser_d   = 1'b0;
            done_d  = 1'b1;
            if (GAP_TICKS == 0) begin
              state_d = IDLE;
            end else begin
              gap_cnt_d = GAP_INIT;
              state_d   = GAP;
            end
          end else begin
            ser_d     = shreg_q[DATA_W-1];
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_freq1) begin
    // NOTE: f2_dly resets high so a freq_2 already high at reset release is not seen as a rising edge.
    if (rst_key1) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ser_q     <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      f2_dly_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge _d values.
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ser_q     <= ser_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      f2_dly_q  <= f2_dly_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: one instance with a 2-tick gap, one with none.
// Words are queued when sent; a negedge monitor reassembles each frame and compares it.
module tb_pattern_serializer;

  localparam int GAP_A = 2;
  localparam int GAP_B = 0;
  localparam int TP    = 8;   // freq_2 period in clk cycles
  localparam int W     = 16;

  logic        clk;
  logic        freq_2;
  int          ph;
  logic [1:0]  rst;
  logic [1:0]  din_valid;
  logic [15:0] din [2];
  logic [1:0]  dr, so, fo, bz, dp;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  // monitor state, one slot per instance
  bit          in_frame [2];
  int          len      [2];
  logic [15:0] word     [2];
  logic        hold_bit [2];
  bit          hold_err [2];
  int          low_cnt  [2];
  int          low_len  [2];
  bit          rdy_wait [2];
  int          rcnt     [2];
  int          done_cnt [2];

  pattern_serializer #(.DATA_W(W), .GAP_TICKS(GAP_A)) dut_a (
    .clk_freq1(clk), .rst_key1(rst[0]), .freq_2(freq_2), .din(din[0]),
    .din_valid(din_valid[0]), .din_ready(dr[0]), .ser_out(so[0]),
    .frame_out(fo[0]), .busy(bz[0]), .done_pulse(dp[0]));

  pattern_serializer #(.DATA_W(W), .GAP_TICKS(GAP_B)) dut_b (
    .clk_freq1(clk), .rst_key1(rst[1]), .freq_2(freq_2), .din(din[1]),
    .din_valid(din_valid[1]), .din_ready(dr[1]), .ser_out(so[1]),
    .frame_out(fo[1]), .busy(bz[1]), .done_pulse(dp[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // freq_2: 4 high / 4 low, changed on negedge so it is stable at every posedge
  initial begin
    ph     = 0;
    freq_2 = 1'b1;
    forever begin
      @(negedge clk);
      ph     = (ph + 1) % TP;
      freq_2 = (ph < TP / 2);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  // Monitor: reassemble frames, compare against the scoreboard, time done/ready.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dp[i]) done_cnt[i]++;
      if (din_valid[i] && dr[i]) check("ready_only_when_idle", {31'd0, bz[i]}, 32'd0);
      if (rst[i]) begin
        in_frame[i] = 1'b0;
        rdy_wait[i] = 1'b0;
        low_cnt[i]  = 0;
      end else if (fo[i]) begin
        if (!in_frame[i]) begin
          low_len[i]  = low_cnt[i];
          in_frame[i] = 1'b1;
          len[i]      = 0;
          word[i]     = '0;
          hold_err[i] = 1'b0;
        end
        if (len[i] % TP == 0) begin
          word[i]     = {word[i][14:0], so[i]};
          hold_bit[i] = so[i];
        end else if (so[i] !== hold_bit[i]) begin
          hold_err[i] = 1'b1;
        end
        len[i]++;
      end else begin
        if (in_frame[i]) begin
          in_frame[i] = 1'b0;
          check("done_at_frame_end", {31'd0, dp[i]}, 32'd1);
          check("ser_low_after_frame", {31'd0, so[i]}, 32'd0);
          check("frame_len", len[i], W * TP);
          check("bit_hold", {31'd0, hold_err[i]}, 32'd0);
          if (i == 0) begin
            if (exp_a.size() == 0) check("unexpected_frame_a", {16'd0, word[i]}, 32'hFFFF_FFFF);
            else check("word_a", {16'd0, word[i]}, {16'd0, exp_a.pop_front()});
          end else begin
            if (exp_b.size() == 0) check("unexpected_frame_b", {16'd0, word[i]}, 32'hFFFF_FFFF);
            else check("word_b", {16'd0, word[i]}, {16'd0, exp_b.pop_front()});
          end
          rdy_wait[i] = 1'b1;
          rcnt[i]     = 0;
          low_cnt[i]  = 0;
        end
        if (rdy_wait[i] && dr[i]) begin
          check("ready_after_frame", rcnt[i], gap_of(i) * TP);
          rdy_wait[i] = 1'b0;
        end else if (rdy_wait[i] && rcnt[i] > 400) begin
          check("ready_timeout", rcnt[i], gap_of(i) * TP);
          rdy_wait[i] = 1'b0;
        end
        rcnt[i]++;
        low_cnt[i]++;
      end
    end
  end

  // Present a word and wait for the handshake; returns at posedge+1 after it.
  task automatic send(input int i, input logic [15:0] w, input bit push, input bit keep);
    int t;
    din[i]       = w;
    din_valid[i] = 1'b1;
    if (push) begin
      if (i == 0) exp_a.push_back(w);
      else        exp_b.push_back(w);
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (dr[i]) break;
      t++;
      if (t > 1000) begin
        check("handshake_timeout", t, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) din_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (dr[i] && !bz[i] && !fo[i]) break;
      t++;
      if (t > 2000) begin
        check("idle_timeout", t, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int dc;
    rst       = 2'b11;
    din_valid = 2'b00;
    din[0]    = '0;
    din[1]    = '0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; in_frame[i] = 0; rdy_wait[i] = 0; low_cnt[i] = 0; low_len[i] = 0;
      len[i] = 0; rcnt[i] = 0; hold_err[i] = 0; hold_bit[i] = 0; word[i] = '0;
    end

    // Reset with freq_2 toggling, release so the first free edge sees freq_2 high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("outputs_in_reset", {27'd0, dr[i], so[i], fo[i], bz[i], dp[i]}, 32'd0);
    @(posedge clk);
    #1;
    while (ph != 1) begin
      @(posedge clk);
      #1;
    end
    rst = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("first_post_reset", {27'd0, dr[i], so[i], fo[i], bz[i], dp[i]}, 32'b10000);
    repeat (12) @(negedge clk);
    check("quiet_after_reset", {28'd0, fo[0], fo[1], bz[0], bz[1]}, 32'd0);
    @(posedge clk);
    #1;

    // Single frame.
    send(0, 16'hA5C3, 1'b1, 1'b0);
    wait_idle(0);
    check("single_done_count", done_cnt[0], 1);

    // Back-to-back with din_valid held: the second word waits for IDLE.
    // Low time between frames = GAP_A gap ticks plus the tick ARM waits for.
    send(0, 16'hFFFF, 1'b1, 1'b1);
    send(0, 16'h0001, 1'b1, 1'b0);
    wait_idle(0);
    check("b2b_frame_low", low_len[0], (GAP_A + 1) * TP);
    check("b2b_done_count", done_cnt[0], 3);

    // Handshake in the same cycle as a tick: that tick is ignored.
    while (ph != TP - 1) begin
      @(posedge clk);
      #1;
    end
    din[0]       = 16'h5A3C;
    din_valid[0] = 1'b1;
    exp_a.push_back(16'h5A3C);
    @(posedge clk);
    #1;
    din_valid[0] = 1'b0;
    check("coincident_busy", {31'd0, bz[0]}, 32'd1);
    check("coincident_no_frame", {31'd0, fo[0]}, 32'd0);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!fo[0] && cnt < 50);
    check("coincident_frame_delay", cnt, TP);
    wait_idle(0);

    // Reset after 5 bits of a frame; the partial word is discarded.
    send(0, 16'hA5C3, 1'b0, 1'b0);
    cnt = 0;
    while (!fo[0] && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    repeat (5 * TP) @(posedge clk);
    #1;
    dc     = done_cnt[0];
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", {27'd0, dr[0], so[0], fo[0], bz[0], dp[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (3 * TP * W) @(posedge clk);
    #1;
    check("midreset_no_done", done_cnt[0], dc);
    send(0, 16'h8001, 1'b1, 1'b0);
    wait_idle(0);

    // Zero-gap instance: done and ready coincide, next frame one tick later.
    send(1, 16'hC0DE, 1'b1, 1'b1);
    send(1, 16'h0F0F, 1'b1, 1'b0);
    wait_idle(1);
    check("zero_gap_frame_low", low_len[1], (GAP_B + 1) * TP);

    repeat (4) @(posedge clk);
    check("final_done_a", done_cnt[0], 5);
    check("final_done_b", done_cnt[1], 2);
    check("scoreboard_empty", exp_a.size() + exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
